// File: rtl/mem_load_responder.sv
// Target end of the memory-load bus: buffers word writes for instruction memory and
// drains them when granted, and services one in-order readback at a time behind them.
module mem_load_responder #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_en,
   input  logic              mem_rd_wr,
   input  logic [31:0]       mem_add,
   input  logic [31:0]       mem_data,
   output logic [31:0]       rd_data,
   output logic              rd_valid,
   input  logic              imem_grant,
   output logic              imem_we,
   output logic              imem_re,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic [31:0]       imem_rdata,
   output logic [2:0]        status,
   output logic [15:0]       wr_count
);

   // state    | meaning
   // IDLE     | no read outstanding
   // RD_WAIT  | read latched, waiting for empty FIFO and grant
   // RD_ISSUE | imem_re driven for this cycle
   // RD_DATA  | imem_rdata captured into rd_data, rd_valid pulsed
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_ISSUE, RD_DATA} state_t;

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   state_t             state;
   logic [ADDR_W+31:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr;
   logic [PTR_W:0]     rd_ptr;
   logic [ADDR_W-1:0]  rd_addr;

   logic               fifo_empty;
   logic               fifo_full;
   logic               misalign;
   logic               out_of_range;
   logic               addr_ok;
   logic               wr_req;
   logic               rd_req;
   logic               push;
   logic               pop;
   logic               overflow;
   logic [ADDR_W+31:0] head;

   assign fifo_empty   = (wr_ptr == rd_ptr);
   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign fifo_full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

   assign misalign     = mem_en && (mem_add[1:0] != 2'b00);
   assign out_of_range = mem_en && (mem_add[31:ADDR_W+2] != '0);
   assign addr_ok      = mem_en && !misalign && !out_of_range;
   assign wr_req       = addr_ok && mem_rd_wr;
   assign rd_req       = addr_ok && !mem_rd_wr;

   // Full is judged before any same-cycle pop, so a pop never makes room for this push.
   assign push         = wr_req && !fifo_full;
   assign pop          = !fifo_empty && imem_grant && (state != RD_DATA);
   assign overflow     = (wr_req && fifo_full) || (rd_req && (state != IDLE));
   assign head         = fifo_mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= {mem_add[ADDR_W+1:2], mem_data};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rd_addr    <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         imem_we    <= 1'b0;
         imem_re    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         status     <= '0;
         wr_count   <= '0;
      end else begin
         imem_we    <= 1'b0;
         imem_re    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         rd_valid   <= 1'b0;
         status     <= status | {out_of_range, misalign, overflow};

         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_count != 16'hFFFF) begin
               wr_count <= wr_count + 16'd1;
            end
         end

         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            imem_we    <= 1'b1;
            imem_addr  <= head[ADDR_W+31:32];
            imem_wdata <= head[31:0];
         end

         // RD_WAIT only issues on an empty FIFO, so it never collides with a pop.
         case (state)
            IDLE: begin
               if (rd_req) begin
                  rd_addr <= mem_add[ADDR_W+1:2];
                  state   <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (fifo_empty && imem_grant) begin
                  imem_re   <= 1'b1;
                  imem_addr <= rd_addr;
                  state     <= RD_ISSUE;
               end
            end
            RD_ISSUE: begin
               state <= RD_DATA;
            end
            RD_DATA: begin
               rd_data  <= imem_rdata;
               rd_valid <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_load_responder.sv
// Directed bench for mem_load_responder with a behavioural imem attached to its port.
module tb_mem_load_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_en;
   logic        mem_rd_wr;
   logic [31:0] mem_add;
   logic [31:0] mem_data;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        imem_grant;
   logic        imem_we;
   logic        imem_re;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic [31:0] imem_rdata;
   logic [2:0]  status;
   logic [15:0] wr_count;

   int tests  = 0;
   int failed = 0;

   logic [31:0] imem_model [0:1023];
   logic [9:0]  we_addr_q[$];
   logic [31:0] we_data_q[$];
   int          rv_cnt = 0;
   int          viol   = 0;

   always #5 clock = ~clock;

   mem_load_responder #(.FIFO_DEPTH(4), .ADDR_W(10)) dut (
      .clock      (clock),
      .reset      (reset),
      .mem_en     (mem_en),
      .mem_rd_wr  (mem_rd_wr),
      .mem_add    (mem_add),
      .mem_data   (mem_data),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .imem_grant (imem_grant),
      .imem_we    (imem_we),
      .imem_re    (imem_re),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .imem_rdata (imem_rdata),
      .status     (status),
      .wr_count   (wr_count)
   );

   always @(posedge clock) begin
      if (imem_we) begin
         imem_model[imem_addr] <= imem_wdata;
         we_addr_q.push_back(imem_addr);
         we_data_q.push_back(imem_wdata);
      end
      if (imem_re) imem_rdata <= imem_model[imem_addr];
      if (rd_valid) rv_cnt++;
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (imem_we && imem_re) viol++;
         if (!imem_we && !imem_re && (imem_addr != 0 || imem_wdata != 0)) viol++;
         if (imem_re && imem_wdata != 0) viol++;
      end
   end

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; mem_en = 1'b0; mem_rd_wr = 1'b0; mem_add = '0; mem_data = '0;
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = a; mem_data = d;
      cyc();
      mem_en = 1'b0; mem_rd_wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a);
      mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = a; mem_data = '0;
      cyc();
      mem_en = 1'b0;
   endtask

   task automatic test_reset();
      imem_grant = 1'b0;
      do_reset();
      tests++;
      if ({rd_data, rd_valid, imem_we, imem_re, imem_addr, imem_wdata, status, wr_count} !== '0) begin
         failed++;
         $display("FAIL reset_outputs: rd_data=%h rd_valid=%b we=%b re=%b addr=%h wdata=%h status=%b wr_count=%0d, required all 0",
                  rd_data, rd_valid, imem_we, imem_re, imem_addr, imem_wdata, status, wr_count);
      end
   endtask

   task automatic test_basic_writes();
      int base;
      logic [31:0] exp_d [3];
      exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33;
      do_reset();
      imem_grant = 1'b1;
      base = we_addr_q.size();
      bus_write(32'h0, 32'h11);
      bus_write(32'h4, 32'h22);
      bus_write(32'h8, 32'h33);
      cyc(4);
      tests++;
      if (we_addr_q.size() - base != 3) begin
         failed++;
         $display("FAIL basic_we_count: got %0d strobes, required 3", we_addr_q.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (we_addr_q[base+i] !== 10'(i) || we_data_q[base+i] !== exp_d[i]) begin
               failed++;
               $display("FAIL basic_we_%0d: addr=%0d data=%h, required addr=%0d data=%h",
                        i, we_addr_q[base+i], we_data_q[base+i], i, exp_d[i]);
            end
         end
      end
      tests++;
      if (wr_count !== 16'd3 || status !== 3'b000) begin
         failed++;
         $display("FAIL basic_count: wr_count=%0d status=%b, required 3 and 000", wr_count, status);
      end
   endtask

   task automatic test_overflow();
      int base;
      do_reset();
      imem_grant = 1'b0;
      base = we_addr_q.size();
      for (int i = 0; i < 5; i++) bus_write(32'h20 + 32'(4*i), 32'hA0 + 32'(i));
      cyc(2);
      tests++;
      if (wr_count !== 16'd4 || status !== 3'b001 || we_addr_q.size() != base) begin
         failed++;
         $display("FAIL overflow_fill: wr_count=%0d status=%b strobes=%0d, required 4, 001, 0",
                  wr_count, status, we_addr_q.size() - base);
      end
      imem_grant = 1'b1;
      cyc(8);
      tests++;
      if (we_addr_q.size() - base != 4) begin
         failed++;
         $display("FAIL overflow_drain_count: got %0d strobes, required 4", we_addr_q.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (we_addr_q[base+i] !== 10'(8+i) || we_data_q[base+i] !== 32'hA0 + 32'(i)) begin
               failed++;
               $display("FAIL overflow_drain_%0d: addr=%0d data=%h, required addr=%0d data=%h",
                        i, we_addr_q[base+i], we_data_q[base+i], 8+i, 32'hA0 + 32'(i));
            end
         end
      end
   endtask

   task automatic test_read_after_write();
      logic got;
      logic [31:0] seen;
      int base_rv;
      do_reset();
      imem_grant = 1'b1;
      base_rv = rv_cnt;
      bus_write(32'h10, 32'hCAFE);
      bus_read(32'h10);
      got = 1'b0; seen = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         cyc();
         if (rd_valid) begin got = 1'b1; seen = rd_data; end
      end
      tests++;
      if (!got) begin
         failed++;
         $display("FAIL raw_timeout: no rd_valid within 20 cycles, required one");
      end else if (seen !== 32'hCAFE) begin
         failed++;
         $display("FAIL raw_data: rd_data=%h, required 0000cafe", seen);
      end
      cyc(3);
      tests++;
      if (rv_cnt - base_rv != 1) begin
         failed++;
         $display("FAIL raw_pulses: got %0d rd_valid pulses, required 1", rv_cnt - base_rv);
      end
   endtask

   task automatic test_read_latency();
      imem_grant = 1'b1;
      mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = 32'h4;
      cyc();
      mem_en = 1'b0;
      cyc(2);
      tests++;
      if (rd_valid !== 1'b0 || rd_data !== 32'hCAFE) begin
         failed++;
         $display("FAIL latency_early: rd_valid=%b rd_data=%h after 3 edges, required 0 and held 0000cafe",
                  rd_valid, rd_data);
      end
      cyc();
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h22) begin
         failed++;
         $display("FAIL latency_pulse: rd_valid=%b rd_data=%h after 4 edges, required 1 and 00000022",
                  rd_valid, rd_data);
      end
      cyc();
      tests++;
      if (rd_valid !== 1'b0 || rd_data !== 32'h22) begin
         failed++;
         $display("FAIL latency_hold: rd_valid=%b rd_data=%h, required 0 and 00000022", rd_valid, rd_data);
      end
   endtask

   task automatic test_addr_errors();
      int base;
      do_reset();
      imem_grant = 1'b1;
      base = we_addr_q.size();
      bus_write(32'h6, 32'h55);
      cyc(3);
      tests++;
      if (status !== 3'b010 || wr_count !== 16'd0 || we_addr_q.size() != base) begin
         failed++;
         $display("FAIL misalign: status=%b wr_count=%0d strobes=%0d, required 010, 0, 0",
                  status, wr_count, we_addr_q.size() - base);
      end
      bus_write(32'h1000, 32'h66);
      cyc(3);
      tests++;
      if (status !== 3'b110 || wr_count !== 16'd0 || we_addr_q.size() != base) begin
         failed++;
         $display("FAIL range: status=%b wr_count=%0d strobes=%0d, required 110, 0, 0",
                  status, wr_count, we_addr_q.size() - base);
      end
      do_reset();
      bus_write(32'h1002, 32'h77);
      cyc(2);
      tests++;
      if (status !== 3'b110 || wr_count !== 16'd0) begin
         failed++;
         $display("FAIL both_errs: status=%b wr_count=%0d, required 110, 0", status, wr_count);
      end
      base = we_addr_q.size();
      bus_write(32'hFFC, 32'h88);
      cyc(3);
      tests++;
      if (wr_count !== 16'd1 || we_addr_q.size() - base != 1 || status !== 3'b110) begin
         failed++;
         $display("FAIL top_word: wr_count=%0d strobes=%0d status=%b, required 1, 1, 110",
                  wr_count, we_addr_q.size() - base, status);
      end else begin
         tests++;
         if (we_addr_q[base] !== 10'd1023 || we_data_q[base] !== 32'h88) begin
            failed++;
            $display("FAIL top_word_addr: addr=%0d data=%h, required 1023, 00000088",
                     we_addr_q[base], we_data_q[base]);
         end
      end
   endtask

   task automatic test_back_to_back_reads();
      int base_rv;
      do_reset();
      imem_grant = 1'b0;
      base_rv = rv_cnt;
      bus_read(32'h0);
      bus_read(32'h4);
      cyc(4);
      tests++;
      if (status !== 3'b001 || rv_cnt != base_rv) begin
         failed++;
         $display("FAIL rd_overflow: status=%b pulses=%0d, required 001, 0", status, rv_cnt - base_rv);
      end
      imem_grant = 1'b1;
      cyc(10);
      tests++;
      if (rv_cnt - base_rv != 1 || rd_data !== 32'h11) begin
         failed++;
         $display("FAIL rd_overflow_result: pulses=%0d rd_data=%h, required 1, 00000011",
                  rv_cnt - base_rv, rd_data);
      end
   endtask

   task automatic test_reset_mid();
      int base_we;
      int base_rv;
      do_reset();
      imem_grant = 1'b0;
      bus_write(32'h40, 32'hDEAD);
      bus_write(32'h44, 32'hBEEF);
      bus_read(32'h40);
      cyc();
      base_we = we_addr_q.size();
      base_rv = rv_cnt;
      reset = 1'b1; imem_grant = 1'b1;
      cyc();
      tests++;
      if ({rd_data, rd_valid, imem_we, imem_re, imem_addr, imem_wdata, status, wr_count} !== '0) begin
         failed++;
         $display("FAIL mid_reset_outputs: rd_valid=%b we=%b re=%b addr=%h status=%b wr_count=%0d, required all 0",
                  rd_valid, imem_we, imem_re, imem_addr, status, wr_count);
      end
      cyc();
      reset = 1'b0;
      cyc(10);
      tests++;
      if (we_addr_q.size() != base_we || rv_cnt != base_rv) begin
         failed++;
         $display("FAIL mid_reset_discard: strobes=%0d pulses=%0d, required 0, 0",
                  we_addr_q.size() - base_we, rv_cnt - base_rv);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) imem_model[i] = '0;
      imem_rdata = '0;
      reset = 1'b1; mem_en = 1'b0; mem_rd_wr = 1'b0; mem_add = '0; mem_data = '0; imem_grant = 1'b0;
      test_reset();
      test_basic_writes();
      test_overflow();
      test_read_after_write();
      test_read_latency();
      test_addr_errors();
      test_back_to_back_reads();
      test_reset_mid();
      tests++;
      if (viol != 0) begin
         failed++;
         $display("FAIL strobe_rules: %0d cycles broke we/re exclusivity or zero idle bus, required 0", viol);
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
